// File: rtl/control_unit_decode.sv
// Decode-stage control unit: decodes the fetched instruction into EX/WB control fields,
// registers them for EX, and handles load-use bubbles, EX flushes and WB->EX forwarding selects.
module control_unit_decode #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Inst_F,
    input  logic        flush,
    output logic [31:0] Inst_decode_reg,
    output logic        Hold_decode_reg,
    output logic        stall_F,
    output logic [1:0]  MemRW_decode_reg,
    output logic        RegWen_decode_reg,
    output logic [2:0]  LdSel_decode_reg,
    output logic [1:0]  WBSel_decode_reg,
    output logic        CSRSel_decode_reg,
    output logic [2:0]  ImmSel_decode_reg,
    output logic        ASel_decode_reg,
    output logic        BSel_decode_reg,
    output logic        BrUn_decode_reg,
    output logic [3:0]  ALUSel_decode_reg,
    output logic        FwdA_decode_reg,
    output logic        FwdB_decode_reg
);
    localparam int unsigned REG_AW = 5;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_REG    = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;

    typedef struct packed {
        logic [1:0] mem_rw;
        logic       reg_wen;
        logic [2:0] ld_sel;
        logic [1:0] wb_sel;
        logic       csr_sel;
        logic [2:0] imm_sel;
        logic       a_sel;
        logic       b_sel;
        logic       br_un;
        logic [3:0] alu_sel;
    } ctrl_t;

    localparam ctrl_t NOP_CTRL = '{mem_rw: 2'b00, reg_wen: 1'b0, ld_sel: 3'd0, wb_sel: 2'b00,
                                   csr_sel: 1'b0, imm_sel: 3'b000, a_sel: 1'b0, b_sel: 1'b1,
                                   br_un: 1'b0, alu_sel: 4'b0000};

    logic [31:0]       r_inst;
    ctrl_t             r_ctrl;
    logic              r_hold;
    logic              r_fwd_a;
    logic              r_fwd_b;

    ctrl_t             w_dec;
    logic [4:0]        w_op;
    logic [2:0]        w_f3;
    logic [REG_AW-1:0] w_rd;
    logic [REG_AW-1:0] w_rs1;
    logic [REG_AW-1:0] w_rs2;
    logic [REG_AW-1:0] w_ex_rd;
    logic              w_rd_wr;
    logic              w_rs1_used;
    logic              w_rs2_used;
    logic              w_ex_load;
    logic              w_hz;
    logic              w_fwd_a;
    logic              w_fwd_b;

    assign w_op    = Inst_F[6:2];
    assign w_f3    = Inst_F[14:12];
    assign w_rd    = Inst_F[11:7];
    assign w_rs1   = Inst_F[19:15];
    assign w_rs2   = Inst_F[24:20];
    assign w_ex_rd = r_inst[11:7];

    // Instruction decode; unknown opcodes fall through to NOP controls
    always_comb begin
        w_dec      = NOP_CTRL;
        w_rd_wr    = 1'b0;
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        case (w_op)
            OP_REG: begin
                w_dec.b_sel   = 1'b0;
                w_dec.alu_sel = {Inst_F[30], w_f3};
                w_rd_wr       = 1'b1;
                w_rs1_used    = 1'b1;
                w_rs2_used    = 1'b1;
            end
            OP_IMM: begin
                w_dec.alu_sel = {(w_f3 == 3'b101) ? Inst_F[30] : 1'b0, w_f3};
                w_rd_wr       = 1'b1;
                w_rs1_used    = 1'b1;
            end
            OP_LOAD: begin
                w_dec.wb_sel = 2'b01;
                case (w_f3)
                    3'b010:  w_dec.ld_sel = 3'd0;
                    3'b001:  w_dec.ld_sel = 3'd1;
                    3'b101:  w_dec.ld_sel = 3'd2;
                    3'b000:  w_dec.ld_sel = 3'd3;
                    3'b100:  w_dec.ld_sel = 3'd4;
                    default: w_dec.ld_sel = 3'd0;
                endcase
                w_rd_wr    = 1'b1;
                w_rs1_used = 1'b1;
            end
            OP_STORE: begin
                w_dec.imm_sel = 3'b001;
                case (w_f3)
                    3'b010:  w_dec.mem_rw = 2'b01;
                    3'b001:  w_dec.mem_rw = 2'b10;
                    3'b000:  w_dec.mem_rw = 2'b11;
                    default: w_dec.mem_rw = 2'b00;
                endcase
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
            end
            OP_BRANCH: begin
                w_dec.imm_sel = 3'b010;
                w_dec.a_sel   = 1'b1;
                w_dec.br_un   = w_f3[1];
                w_rs1_used    = 1'b1;
                w_rs2_used    = 1'b1;
            end
            OP_JAL: begin
                w_dec.imm_sel = 3'b100;
                w_dec.a_sel   = 1'b1;
                w_dec.wb_sel  = 2'b10;
                w_rd_wr       = 1'b1;
            end
            OP_JALR: begin
                w_dec.wb_sel = 2'b10;
                w_rd_wr      = 1'b1;
                w_rs1_used   = 1'b1;
            end
            OP_LUI: begin
                w_dec.imm_sel = 3'b011;
                w_dec.alu_sel = 4'b1111;
                w_rd_wr       = 1'b1;
            end
            OP_AUIPC: begin
                w_dec.imm_sel = 3'b011;
                w_dec.a_sel   = 1'b1;
                w_rd_wr       = 1'b1;
            end
            OP_SYSTEM: begin
                w_dec.wb_sel  = 2'b11;
                w_dec.csr_sel = (w_f3 == 3'b001) || (w_f3 == 3'b101);
                w_dec.imm_sel = (w_f3 == 3'b101) ? 3'b101 : 3'b000;
                w_rd_wr       = 1'b1;
                w_rs1_used    = (w_f3 == 3'b001);
            end
            default: ;
        endcase
        w_dec.reg_wen = w_rd_wr && (w_rd != REG_AW'(0));
    end

    // Load in EX whose result is needed now: bubble EX and hold fetch
    assign w_ex_load = (r_inst[6:2] == OP_LOAD);
    assign w_hz      = w_ex_load && (w_ex_rd != REG_AW'(0)) &&
                       ((w_rs1_used && (w_rs1 == w_ex_rd)) || (w_rs2_used && (w_rs2 == w_ex_rd)));
    assign stall_F   = w_hz && !flush && !rst;

    assign w_fwd_a = r_ctrl.reg_wen && (w_ex_rd == w_rs1) && w_rs1_used && (w_rs1 != REG_AW'(0));
    assign w_fwd_b = r_ctrl.reg_wen && (w_ex_rd == w_rs2) && w_rs2_used && (w_rs2 != REG_AW'(0));

    always_ff @(posedge clk) begin
        if (rst || flush || w_hz) begin
            r_inst  <= NOP_INST;
            r_ctrl  <= NOP_CTRL;
            r_hold  <= stall_F;
            r_fwd_a <= 1'b0;
            r_fwd_b <= 1'b0;
        end else begin
            r_inst  <= Inst_F;
            r_ctrl  <= w_dec;
            r_hold  <= 1'b0;
            r_fwd_a <= w_fwd_a;
            r_fwd_b <= w_fwd_b;
        end
    end

    assign Inst_decode_reg   = r_inst;
    assign Hold_decode_reg   = r_hold;
    assign MemRW_decode_reg  = r_ctrl.mem_rw;
    assign RegWen_decode_reg = r_ctrl.reg_wen;
    assign LdSel_decode_reg  = r_ctrl.ld_sel;
    assign WBSel_decode_reg  = r_ctrl.wb_sel;
    assign CSRSel_decode_reg = r_ctrl.csr_sel;
    assign ImmSel_decode_reg = r_ctrl.imm_sel;
    assign ASel_decode_reg   = r_ctrl.a_sel;
    assign BSel_decode_reg   = r_ctrl.b_sel;
    assign BrUn_decode_reg   = r_ctrl.br_un;
    assign ALUSel_decode_reg = r_ctrl.alu_sel;
    assign FwdA_decode_reg   = r_fwd_a;
    assign FwdB_decode_reg   = r_fwd_b;

endmodule
